// File: rtl/dram_ctrl_pkg.sv
// Shared types and sizes for the 512x1 distributed-RAM arbiter slice.
package dram_ctrl_pkg;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 512;
    localparam int NREQ   = 2;

    typedef enum logic {ARB, CLEAR} state_t;
    typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/dram_512x1_arbiter_if.sv
// Requester-side bit access bus: per-requester ops in, accept/read strobes out.
interface dram_512x1_arbiter_if;
    import dram_ctrl_pkg::*;

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] we;
    addr_t           addr0;
    addr_t           addr1;
    logic [NREQ-1:0] wdata;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] rvalid;
    logic            rdata;

    modport master (output req, we, addr0, addr1, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr0, addr1, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dram_512x1_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie.
module rr_arb2
    import dram_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            enable,
    input  logic            advance,
    output logic [NREQ-1:0] gnt
);
    logic ptr;

    always_comb begin
        gnt = '0;
        if (enable) begin
            if (&req) gnt = ptr ? 2'b10 : 2'b01;
            else      gnt = req;
        end
    end

    // After a grant the other requester gets priority; idle cycles leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ptr <= 1'b0;
        else if (advance) ptr <= gnt[0];
    end
endmodule

// File: rtl/dram_512x1_arbiter.sv
// Round-robin front end for a RAM512X1S with a full-array clear engine.
module dram_512x1_arbiter
    import dram_ctrl_pkg::*;
#(
    parameter bit   CLEAR_ON_RESET = 1'b1,
    parameter logic CLEAR_VAL      = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dram_512x1_arbiter_if.slave  bus,
    input  logic                 clear_start,
    output logic                 clear_busy,
    output addr_t                ram_a,
    output logic                 ram_d,
    output logic                 ram_we,
    input  logic                 ram_o
);
    localparam state_t RST_STATE = CLEAR_ON_RESET ? CLEAR : ARB;

    state_t          state, state_nxt;
    addr_t           cnt;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] rd_pend;
    logic [NREQ-1:0] rvalid;
    logic            rdata;
    logic            arb_en;
    logic            acc;
    logic            sel;

    // Gating on rst_n keeps gnt low while reset is held, not just after it.
    assign arb_en = rst_n && (state == ARB) && !clear_start;
    assign acc    = |gnt;
    assign sel    = gnt[1];

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.req),
        .enable  (arb_en),
        .advance (acc),
        .gnt     (gnt)
    );

    assign bus.gnt    = gnt;
    assign bus.rvalid = rvalid;
    assign bus.rdata  = rdata;
    assign clear_busy = (state == CLEAR);

    always_comb begin
        state_nxt = state;
        case (state)
            ARB:     if (clear_start) state_nxt = CLEAR;
            CLEAR:   if (cnt == addr_t'(DEPTH - 1)) state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RST_STATE;
        else        state <= state_nxt;
    end

    // Read data is sampled at the end of the cycle the address is on the RAM,
    // so a write in the previous cycle has already committed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            ram_a   <= '0;
            ram_d   <= 1'b0;
            ram_we  <= 1'b0;
            rd_pend <= '0;
            rvalid  <= '0;
            rdata   <= 1'b0;
        end else begin
            ram_we  <= 1'b0;
            rd_pend <= '0;
            if (state == CLEAR) begin
                ram_a  <= cnt;
                ram_d  <= CLEAR_VAL;
                ram_we <= 1'b1;
                cnt    <= cnt + addr_t'(1);
            end else if (acc) begin
                ram_a   <= sel ? bus.addr1 : bus.addr0;
                ram_d   <= bus.wdata[sel];
                ram_we  <= bus.we[sel];
                rd_pend <= gnt & ~bus.we;
            end
            rvalid <= rd_pend;
            if (|rd_pend) rdata <= ram_o;
        end
    end
endmodule

// File: tb/tb_dram_512x1_arbiter.sv
// Randomized and directed checks of the arbiter against a bit-array reference model.
module tb_dram_512x1_arbiter;
    import dram_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear_start = 1'b0;
    logic       clear_busy;
    logic [8:0] ram_a;
    logic       ram_d, ram_we, ram_o;

    int passed = 0;
    int total  = 0;

    bit mdl_mem [512];
    bit mdl_ptr;

    logic ram_mem [512];

    dram_512x1_arbiter_if bus ();

    dram_512x1_arbiter #(.CLEAR_ON_RESET(1'b1), .CLEAR_VAL(1'b0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .ram_a       (ram_a),
        .ram_d       (ram_d),
        .ram_we      (ram_we),
        .ram_o       (ram_o)
    );

    // RAM512X1S stand-in: synchronous write, asynchronous read.
    always @(posedge clk) if (ram_we) ram_mem[ram_a] <= ram_d;
    assign ram_o = ram_mem[ram_a];

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [8:0] a0,
                         input logic [8:0] a1, input logic [1:0] d);
        bus.req   = r;
        bus.we    = w;
        bus.addr0 = a0;
        bus.addr1 = a1;
        bus.wdata = d;
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < 512; i++) mdl_mem[i] = 1'b0;
    endtask

    task automatic test_reset();
        bit         seen [512];
        int         busy = 0, pulses = 0, distinct = 0, first_idle = -1, gcyc = -1, c = 0;
        logic [1:0] rv1 = '0, rv2 = '0;
        logic       rd2 = 1'b1;
        bit         done = 0;
        @(negedge clk);
        total++; if (bus.gnt !== 2'b00) $display("FAIL rst_gnt got %b want 00", bus.gnt); else passed++;
        total++; if (bus.rvalid !== 2'b00) $display("FAIL rst_rvalid got %b want 00", bus.rvalid); else passed++;
        total++; if (bus.rdata !== 1'b0) $display("FAIL rst_rdata got %b want 0", bus.rdata); else passed++;
        total++; if (ram_a !== 9'h000) $display("FAIL rst_ram_a got %h want 000", ram_a); else passed++;
        total++; if (ram_d !== 1'b0) $display("FAIL rst_ram_d got %b want 0", ram_d); else passed++;
        total++; if (ram_we !== 1'b0) $display("FAIL rst_ram_we got %b want 0", ram_we); else passed++;
        total++; if (clear_busy !== 1'b1) $display("FAIL rst_busy got %b want 1", clear_busy); else passed++;
        drive(2'b01, 2'b00, 9'h1FF, 9'h000, 2'b00);
        @(negedge clk);
        total++; if (bus.gnt !== 2'b00) $display("FAIL rst_gnt_held got %b want 00", bus.gnt); else passed++;
        while (!done && c < 700) begin
            cyc();
            if (c == 0) rst_n = 1'b1;
            if (gcyc >= 0 && c == gcyc + 1) bus.req = 2'b00;
            @(negedge clk);
            if (clear_busy) busy++;
            else if (first_idle < 0) first_idle = c;
            if (ram_we) begin pulses++; seen[ram_a] = 1'b1; end
            if (gcyc < 0 && bus.gnt[0]) gcyc = c;
            if (gcyc >= 0 && c == gcyc + 1) rv1 = bus.rvalid;
            if (gcyc >= 0 && c == gcyc + 2) begin rv2 = bus.rvalid; rd2 = bus.rdata; done = 1; end
            c++;
        end
        for (int i = 0; i < 512; i++) distinct += int'(seen[i]);
        total++; if (!done) $display("FAIL init_timeout got no grant+read within %0d cycles", c); else passed++;
        total++; if (busy != 512) $display("FAIL init_busy_cycles got %0d want 512", busy); else passed++;
        total++; if (pulses != 512) $display("FAIL init_we_pulses got %0d want 512", pulses); else passed++;
        total++; if (distinct != 512) $display("FAIL init_addr_cover got %0d want 512", distinct); else passed++;
        total++; if (gcyc != first_idle) $display("FAIL init_first_gnt got cycle %0d want %0d", gcyc, first_idle); else passed++;
        total++; if (rv1 !== 2'b00) $display("FAIL init_rvalid_early got %b want 00", rv1); else passed++;
        total++; if (rv2 !== 2'b01) $display("FAIL init_rvalid got %b want 01", rv2); else passed++;
        total++; if (rd2 !== 1'b0) $display("FAIL init_rdata got %b want 0", rd2); else passed++;
        mdl_clear();
        mdl_ptr = 1'b1;
    endtask

    task automatic test_write_readback();
        cyc(); drive(2'b01, 2'b01, 9'h0A5, 9'h000, 2'b01);
        @(negedge clk);
        total++; if (bus.gnt !== 2'b01) $display("FAIL wr_gnt got %b want 01", bus.gnt); else passed++;
        mdl_mem[9'h0A5] = 1'b1;
        cyc(); drive(2'b01, 2'b00, 9'h0A5, 9'h000, 2'b00);
        @(negedge clk);
        total++; if (bus.gnt !== 2'b01) $display("FAIL rd_gnt got %b want 01", bus.gnt); else passed++;
        cyc(); drive(2'b00, 2'b00, 9'h000, 9'h000, 2'b00);
        @(negedge clk);
        total++; if (bus.rvalid !== 2'b00) $display("FAIL rb_rvalid_early got %b want 00", bus.rvalid); else passed++;
        cyc();
        @(negedge clk);
        total++; if (bus.rvalid !== 2'b01) $display("FAIL rb_rvalid got %b want 01", bus.rvalid); else passed++;
        total++; if (bus.rdata !== 1'b1) $display("FAIL rb_rdata got %b want 1", bus.rdata); else passed++;
        mdl_ptr = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [1:0] eg, erv;
        // Requester 1 writes 0x003 (used later) and hands priority back to 0.
        cyc(); drive(2'b10, 2'b10, 9'h000, 9'h003, 2'b10);
        @(negedge clk);
        total++; if (bus.gnt !== 2'b10) $display("FAIL rr_pre_gnt got %b want 10", bus.gnt); else passed++;
        mdl_mem[9'h003] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (k < 6) drive(2'b11, 2'b00, 9'h0A5, 9'h010, 2'b00);
            else       drive(2'b00, 2'b00, 9'h000, 9'h000, 2'b00);
            @(negedge clk);
            eg  = (k < 6) ? ((k % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            erv = (k >= 2) ? ((k % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            total++; if (bus.gnt !== eg) $display("FAIL rr_gnt k=%0d got %b want %b", k, bus.gnt, eg); else passed++;
            total++; if (bus.rvalid !== erv) $display("FAIL rr_rvalid k=%0d got %b want %b", k, bus.rvalid, erv); else passed++;
            if (erv != 2'b00) begin
                total++;
                if (bus.rdata !== mdl_mem[(erv == 2'b01) ? 9'h0A5 : 9'h010])
                    $display("FAIL rr_rdata k=%0d got %b want %b", k, bus.rdata, erv == 2'b01);
                else passed++;
            end
        end
        mdl_ptr = 1'b0;
    endtask

    task automatic test_clear_mid();
        int nog = 0;
        bit got = 0;
        cyc(); drive(2'b10, 2'b00, 9'h000, 9'h003, 2'b00);
        @(negedge clk);
        total++; if (bus.gnt !== 2'b10) $display("FAIL cm_gnt got %b want 10", bus.gnt); else passed++;
        cyc(); drive(2'b01, 2'b00, 9'h003, 9'h000, 2'b00); clear_start = 1'b1;
        @(negedge clk);
        total++; if (bus.gnt !== 2'b00) $display("FAIL cm_start_gnt got %b want 00", bus.gnt); else passed++;
        if (bus.gnt == 2'b00) nog++;
        cyc(); clear_start = 1'b0;
        @(negedge clk);
        total++; if (bus.rvalid !== 2'b10) $display("FAIL cm_rvalid got %b want 10", bus.rvalid); else passed++;
        total++; if (bus.rdata !== 1'b1) $display("FAIL cm_rdata got %b want 1", bus.rdata); else passed++;
        total++; if (clear_busy !== 1'b1) $display("FAIL cm_busy got %b want 1", clear_busy); else passed++;
        if (bus.gnt == 2'b00) nog++;
        for (int c = 0; c < 700 && !got; c++) begin
            cyc();
            @(negedge clk);
            if (bus.gnt != 2'b00) got = 1; else nog++;
        end
        total++; if (!got) $display("FAIL cm_timeout got no grant after %0d cycles", nog); else passed++;
        total++; if (nog != 513) $display("FAIL cm_blocked got %0d want 513", nog); else passed++;
        total++; if (bus.gnt !== 2'b01) $display("FAIL cm_regnt got %b want 01", bus.gnt); else passed++;
        mdl_clear();
        mdl_ptr = 1'b1;
        cyc(); drive(2'b00, 2'b00, 9'h000, 9'h000, 2'b00);
        @(negedge clk);
        cyc();
        @(negedge clk);
        total++; if (bus.rvalid !== 2'b01) $display("FAIL cm_post_rvalid got %b want 01", bus.rvalid); else passed++;
        total++; if (bus.rdata !== 1'b0) $display("FAIL cm_post_rdata got %b want 0", bus.rdata); else passed++;
    endtask

    task automatic test_clear_restart();
        int busy = 0, c = 0;
        bit done = 0;
        cyc(); clear_start = 1'b1;
        @(negedge clk);
        total++; if (clear_busy !== 1'b0) $display("FAIL cr_busy_start got %b want 0", clear_busy); else passed++;
        while (!done && c < 1000) begin
            cyc();
            clear_start = (c == 100);
            @(negedge clk);
            if (clear_busy) busy++; else done = 1;
            c++;
        end
        clear_start = 1'b0;
        total++; if (!done) $display("FAIL cr_timeout got busy %0d cycles", busy); else passed++;
        total++; if (busy != 512) $display("FAIL cr_busy_cycles got %0d want 512", busy); else passed++;
        mdl_clear();
    endtask

    task automatic test_random();
        logic [1:0] ev [0:309];
        logic       ed [0:309];
        logic [1:0] r, w, d, eg;
        logic [8:0] a0, a1, a;
        int         i;
        for (int k = 0; k < 310; k++) begin ev[k] = 2'b00; ed[k] = 1'b0; end
        for (int c = 0; c < 302; c++) begin
            cyc();
            r  = (c < 300) ? 2'($urandom_range(0, 3)) : 2'b00;
            w  = 2'($urandom);
            d  = 2'($urandom);
            a0 = 9'($urandom_range(0, 7));
            a1 = 9'($urandom_range(0, 7));
            drive(r, w, a0, a1, d);
            @(negedge clk);
            eg = (r == 2'b11) ? (mdl_ptr ? 2'b10 : 2'b01) : r;
            total++; if (bus.gnt !== eg) $display("FAIL rnd_gnt c=%0d got %b want %b", c, bus.gnt, eg); else passed++;
            if (eg != 2'b00) begin
                i = eg[1] ? 1 : 0;
                a = (i == 1) ? a1 : a0;
                if (w[i]) mdl_mem[a] = d[i];
                else begin ev[c + 2] = eg; ed[c + 2] = mdl_mem[a]; end
                mdl_ptr = (i == 0);
            end
            total++; if (bus.rvalid !== ev[c]) $display("FAIL rnd_rvalid c=%0d got %b want %b", c, bus.rvalid, ev[c]); else passed++;
            if (ev[c] != 2'b00) begin
                total++; if (bus.rdata !== ed[c]) $display("FAIL rnd_rdata c=%0d got %b want %b", c, bus.rdata, ed[c]); else passed++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int  busy = 0, c = 0;
        bit  rv_seen = 0, done = 0;
        cyc(); drive(2'b01, 2'b00, 9'h1F0, 9'h000, 2'b00);
        @(negedge clk);
        total++; if (bus.gnt !== 2'b01) $display("FAIL rm_gnt got %b want 01", bus.gnt); else passed++;
        cyc();
        total++; if (ram_a !== 9'h1F0) $display("FAIL rm_pre_ram_a got %h want 1f0", ram_a); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (ram_a !== 9'h000) $display("FAIL rm_ram_a got %h want 000", ram_a); else passed++;
        total++; if (ram_we !== 1'b0) $display("FAIL rm_ram_we got %b want 0", ram_we); else passed++;
        total++; if (ram_d !== 1'b0) $display("FAIL rm_ram_d got %b want 0", ram_d); else passed++;
        total++; if (bus.rvalid !== 2'b00) $display("FAIL rm_rvalid got %b want 00", bus.rvalid); else passed++;
        total++; if (bus.rdata !== 1'b0) $display("FAIL rm_rdata got %b want 0", bus.rdata); else passed++;
        total++; if (bus.gnt !== 2'b00) $display("FAIL rm_gnt_rst got %b want 00", bus.gnt); else passed++;
        total++; if (clear_busy !== 1'b1) $display("FAIL rm_busy got %b want 1", clear_busy); else passed++;
        drive(2'b00, 2'b00, 9'h000, 9'h000, 2'b00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.rvalid != 2'b00) rv_seen = 1;
        end
        cyc(); rst_n = 1'b1;
        while (!done && c < 700) begin
            @(negedge clk);
            if (bus.rvalid != 2'b00) rv_seen = 1;
            if (clear_busy) busy++; else done = 1;
            cyc();
            c++;
        end
        total++; if (rv_seen) $display("FAIL rm_no_rvalid got rvalid want none"); else passed++;
        total++; if (busy != 512) $display("FAIL rm_sweep got %0d want 512", busy); else passed++;
        mdl_clear();
        mdl_ptr = 1'b0;
    endtask

    initial begin
        drive(2'b00, 2'b00, 9'h000, 9'h000, 2'b00);
        test_reset();
        test_write_readback();
        test_round_robin();
        test_clear_mid();
        test_clear_restart();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
